// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with a per-register pending scoreboard.
// Ports: clk, rst (sync, active-high); raddr1/raddr2 -> rdata1/rdata2 and busy1/busy2;
//        we/waddr/wdata write port; issue/iaddr mark a destination pending;
//        pending_cnt reports how many registers are pending.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] raddr1,
  input  logic [DEPTH_LOG2-1:0] raddr2,
  output logic [WIDTH-1:0]      rdata1,
  output logic [WIDTH-1:0]      rdata2,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  issue,
  input  logic [DEPTH_LOG2-1:0] iaddr,
  output logic                  busy1,
  output logic                  busy2,
  output logic [DEPTH_LOG2:0]   pending_cnt
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr, iss, inc, dec, fwd1, fwd2;
  logic [WIDTH-1:0] rd1, rd2;
  always_comb begin
    wr     = we && waddr != '0;
    iss    = issue && iaddr != '0;
    inc    = iss && !pend_q[iaddr];
    // A write clears its pending bit unless a new producer claims the same register.
    dec    = wr && pend_q[waddr] && !(iss && iaddr == waddr);
    pend_d = pend_q;
    if (wr) pend_d[waddr] = 1'b0;
    if (iss) pend_d[iaddr] = 1'b1;
    cnt_d  = cnt_q + CW'(inc) - CW'(dec);
    rd1    = raddr1 == '0 ? '0 : mem_q[raddr1];
    rd2    = raddr2 == '0 ? '0 : mem_q[raddr2];
  end
`ifdef REG_FILE_BYPASS_EN
  assign fwd1 = wr && raddr1 == waddr;
  assign fwd2 = wr && raddr2 == waddr;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign rdata1      = fwd1 ? wdata : rd1;
  assign rdata2      = fwd2 ? wdata : rd2;
  assign busy1       = pend_q[raddr1] && !fwd1;
  assign busy2       = pend_q[raddr2] && !fwd2;
  assign pending_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) mem_q[waddr] <= wdata;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
